// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM controller:
// chip indices, FSM states and select decode.
package sram_ctrl_pkg;

  localparam int SEL_BASE_RAM = 0;
  localparam int SEL_EXT_RAM  = 1;

  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_WREC  = 3'd3,
    S_ERR   = 3'd4
  } sram_state_t;

  // Active-high chip hit; all-zero means unmapped or multi-hot.
  function automatic logic [1:0] chip_decode(
    input logic [15:0] sel
  );
    logic [1:0] hit;
    hit = 2'b00;
    unique case (1'b1)
      (sel == 16'h0001): hit[SEL_BASE_RAM] = 1'b1;
      (sel == 16'h0002): hit[SEL_EXT_RAM]  = 1'b1;
      default:           hit = 2'b00;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Wishbone slave driving the base/ext asynchronous SRAMs.
// Every output is registered; access timing is counted here.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RAM_AW       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stb_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic              wb_we_i,
  input  logic [15:0]       wb_sel_i,
  output logic [31:0]       wb_data_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic              ram_data_oe,
  output logic [1:0]        ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n
);

  localparam logic [3:0] RD_LOAD = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES - 1);

  sram_state_t       state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [31:0]       rdata_nx, wd_nx;
  logic              ack_nx, err_nx;
  logic              doe_nx, oe_nx, we_nx;
  logic [1:0]        ce_nx, hit;
  logic [3:0]        be_nx;
  logic [RAM_AW-1:0] addr_nx;
  logic              unused_addr;

  assign hit = chip_decode(wb_sel_i);
  assign unused_addr =
    ^{wb_addr_i[31:RAM_AW+2], wb_addr_i[1:0]};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = wb_data_o;
    ack_nx   = wb_ack_o;
    err_nx   = 1'b0;
    addr_nx  = ram_addr_o;
    wd_nx    = ram_data_o;
    doe_nx   = ram_data_oe;
    ce_nx    = ram_ce_n;
    oe_nx    = ram_oe_n;
    we_nx    = ram_we_n;
    be_nx    = ram_be_n;
    unique case (state)
      S_IDLE: begin
        if (wb_stb_i) begin
          ack_nx  = 1'b0;
          addr_nx = wb_addr_i[RAM_AW+1:2];
          wd_nx   = wb_data_i;
          if (hit == 2'b00) begin
            state_nx = S_ERR;
          end else begin
            ce_nx = ~hit;
            be_nx = 4'b0000;
            if (wb_we_i) begin
              state_nx = S_WRITE;
              cnt_nx   = WR_LOAD;
              doe_nx   = 1'b1;
              we_nx    = 1'b0;
            end else begin
              state_nx = S_READ;
              cnt_nx   = RD_LOAD;
              oe_nx    = 1'b0;
            end
          end
        end
      end
      S_READ: begin
        if (cnt == 4'd0) begin
          rdata_nx = ram_data_i;
          ce_nx    = 2'b11;
          oe_nx    = 1'b1;
          be_nx    = 4'b1111;
          ack_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_WRITE: begin
        if (cnt == 4'd0) begin
          we_nx    = 1'b1;
          state_nx = S_WREC;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      // WE_n already high; CE_n and data held one more cycle.
      S_WREC: begin
        ce_nx    = 2'b11;
        doe_nx   = 1'b0;
        be_nx    = 4'b1111;
        ack_nx   = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        rdata_nx = ZERO_WORD;
        err_nx   = 1'b1;
        ack_nx   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      wb_data_o   <= ZERO_WORD;
      wb_ack_o    <= 1'b1;
      wb_err_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_data_o  <= ZERO_WORD;
      ram_data_oe <= 1'b0;
      ram_ce_n    <= 2'b11;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_be_n    <= 4'b1111;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      wb_data_o   <= rdata_nx;
      wb_ack_o    <= ack_nx;
      wb_err_o    <= err_nx;
      ram_addr_o  <= addr_nx;
      ram_data_o  <= wd_nx;
      ram_data_oe <= doe_nx;
      ram_ce_n    <= ce_nx;
      ram_oe_n    <= oe_nx;
      ram_we_n    <= we_nx;
      ram_be_n    <= be_nx;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: transaction-level
// reference memory plus a bus-level SRAM emulation.
module tb_sram_ctrl;

  localparam int RC_A = 2, WC_A = 2;
  localparam int RC_B = 1, WC_B = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [15:0] sel = '0;
  logic        use_b = 1'b0;

  logic [31:0] a_rdata, a_wd, rdi_a = '0;
  logic        a_ack, a_err, a_doe, a_oe, a_we;
  logic [19:0] a_addr;
  logic [1:0]  a_ce;
  logic [3:0]  a_be;
  logic [31:0] b_rdata, b_wd, rdi_b = '0;
  logic        b_ack, b_err, b_doe, b_oe, b_we;
  logic [19:0] b_addr;
  logic [1:0]  b_ce;
  logic [3:0]  b_be;

  logic [31:0] m_rdata, m_wd;
  logic        m_ack, m_err, m_doe, m_oe, m_we;
  logic [19:0] m_addr;
  logic [1:0]  m_ce;
  logic [3:0]  m_be;

  logic [31:0] sram0[int], sram1[int];
  logic [31:0] ref0[int], ref1[int];
  logic [31:0] exp_do = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.RAM_AW(20), .READ_CYCLES(RC_A), .WRITE_CYCLES(WC_A)) dut_a (
    .clk(clk), .rst(rst), .wb_stb_i(stb), .wb_addr_i(addr),
    .wb_data_i(wdata), .wb_we_i(we), .wb_sel_i(sel),
    .wb_data_o(a_rdata), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .ram_addr_o(a_addr), .ram_data_o(a_wd), .ram_data_i(rdi_a),
    .ram_data_oe(a_doe), .ram_ce_n(a_ce), .ram_oe_n(a_oe),
    .ram_we_n(a_we), .ram_be_n(a_be));

  sram_ctrl #(.RAM_AW(20), .READ_CYCLES(RC_B), .WRITE_CYCLES(WC_B)) dut_b (
    .clk(clk), .rst(rst), .wb_stb_i(stb), .wb_addr_i(addr),
    .wb_data_i(wdata), .wb_we_i(we), .wb_sel_i(sel),
    .wb_data_o(b_rdata), .wb_ack_o(b_ack), .wb_err_o(b_err),
    .ram_addr_o(b_addr), .ram_data_o(b_wd), .ram_data_i(rdi_b),
    .ram_data_oe(b_doe), .ram_ce_n(b_ce), .ram_oe_n(b_oe),
    .ram_we_n(b_we), .ram_be_n(b_be));

  assign m_rdata = use_b ? b_rdata : a_rdata;
  assign m_wd    = use_b ? b_wd    : a_wd;
  assign m_ack   = use_b ? b_ack   : a_ack;
  assign m_err   = use_b ? b_err   : a_err;
  assign m_doe   = use_b ? b_doe   : a_doe;
  assign m_oe    = use_b ? b_oe    : a_oe;
  assign m_we    = use_b ? b_we    : a_we;
  assign m_addr  = use_b ? b_addr  : a_addr;
  assign m_ce    = use_b ? b_ce    : a_ce;
  assign m_be    = use_b ? b_be    : a_be;

  function automatic logic [31:0] mem_rd(input logic [1:0] ce, input logic [19:0] a);
    if (!ce[0]) return sram0.exists(int'(a)) ? sram0[int'(a)] : 32'h0;
    if (!ce[1]) return sram1.exists(int'(a)) ? sram1[int'(a)] : 32'h0;
    return 32'h0BAD_F00D;
  endfunction

  // Asynchronous SRAM emulation of the selected controller's bus.
  always @(negedge clk) begin
    if (!m_we && m_doe) begin
      if (!m_ce[0]) sram0[int'(m_addr)] = m_wd;
      if (!m_ce[1]) sram1[int'(m_addr)] = m_wd;
    end
    rdi_a <= a_oe ? 32'h0BAD_F00D : mem_rd(a_ce, a_addr);
    rdi_b <= b_oe ? 32'h0BAD_F00D : mem_rd(b_ce, b_addr);
  end

  function automatic logic [31:0] ref_rd(input int chip, input int w);
    if (chip == 0) return ref0.exists(w) ? ref0[w] : 32'h0;
    return ref1.exists(w) ? ref1[w] : 32'h0;
  endfunction

  task automatic xfer(
    input logic w, input logic [15:0] s, input logic [31:0] ad, d,
    input bit cont, input bit hold,
    output int lat, output logic [31:0] rd, output int we_lo, oe_lo,
    output bit ovl, output logic [1:0] ce_and, output logic [19:0] ra,
    output bit errs, output bit be_bad);
    if (!cont) @(negedge clk);
    stb = 1'b1; we = w; sel = s; addr = ad; wdata = d;
    lat = 0; we_lo = 0; oe_lo = 0; ovl = 0; ce_and = 2'b11;
    ra = '0; errs = 0; be_bad = 0;
    forever begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        ra = m_addr;
        addr = $urandom; wdata = $urandom; we = ~w; sel = 16'($urandom);
      end
      if (!m_we) we_lo++;
      if (!m_oe) oe_lo++;
      if (!m_we && !m_oe) ovl = 1;
      ce_and &= m_ce;
      if (m_ce != 2'b11 && m_be != 4'h0) be_bad = 1;
      if (m_ack) begin
        if (m_be != 4'hF || m_ce != 2'b11) be_bad = 1;
        break;
      end
      if (lat > 60) break;
    end
    rd = m_rdata; errs = m_err;
    if (!hold) stb = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ack, a_err, a_ce, a_oe, a_we, a_be, a_doe} !== 11'b1_0_11_1_1_1111_0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 10111111110",
               {a_ack, a_err, a_ce, a_oe, a_we, a_be, a_doe});
    end
    n_cmp++;
    if ({a_rdata, a_wd, a_addr} !== 84'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h/%h want 0", a_rdata, a_wd, a_addr);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_base_wr;
    int lat, wl, ol; logic [31:0] rd; bit ov, er, bb;
    logic [1:0] ca; logic [19:0] ra;
    xfer(1'b1, 16'h0001, 32'h0000_0010, 32'hDEADBEEF, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    ref0[4] = 32'hDEADBEEF;
    n_cmp++; if (lat !== WC_A + 2) begin n_bad++; $display("FAIL wr_lat: got %0d want %0d", lat, WC_A + 2); end
    n_cmp++; if (wl !== WC_A) begin n_bad++; $display("FAIL wr_we_low: got %0d want %0d", wl, WC_A); end
    n_cmp++; if ({ca, ra} !== {2'b10, 20'd4}) begin n_bad++; $display("FAIL wr_bus: ce %b addr %h want 10/4", ca, ra); end
    n_cmp++; if (rd !== exp_do || bb || ov || er) begin n_bad++; $display("FAIL wr_side: do %h be %0d ov %0d err %0d want %h/0/0/0", rd, bb, ov, er, exp_do); end
    xfer(1'b0, 16'h0001, 32'h0000_0010, 32'h0, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    exp_do = 32'hDEADBEEF;
    n_cmp++; if (lat !== RC_A + 1) begin n_bad++; $display("FAIL rd_lat: got %0d want %0d", lat, RC_A + 1); end
    n_cmp++; if (rd !== exp_do) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, exp_do); end
    n_cmp++; if ({ol, wl} !== {RC_A, 0} || ca !== 2'b10) begin n_bad++; $display("FAIL rd_bus: oe %0d we %0d ce %b want %0d/0/10", ol, wl, ca, RC_A); end
  endtask

  task automatic test_ext_read;
    int lat, wl, ol; logic [31:0] rd, v; bit ov, er, bb;
    logic [1:0] ca; logic [19:0] ra;
    v = $urandom;
    sram1[20'hFFFFF] = v; ref1[20'hFFFFF] = v;
    xfer(1'b0, 16'h0002, 32'h003F_FFFC, 32'h0, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    exp_do = ref_rd(1, 20'hFFFFF);
    n_cmp++; if ({ca, ra} !== {2'b01, 20'hFFFFF}) begin n_bad++; $display("FAIL ext_bus: ce %b addr %h want 01/fffff", ca, ra); end
    n_cmp++; if (rd !== exp_do || lat !== RC_A + 1) begin n_bad++; $display("FAIL ext_rd: got %h lat %0d want %h lat %0d", rd, lat, exp_do, RC_A + 1); end
  endtask

  task automatic test_unmapped;
    int lat, wl, ol; logic [31:0] rd; bit ov, er, bb;
    logic [1:0] ca; logic [19:0] ra;
    logic [15:0] bad [2];
    bad[0] = 16'h0004; bad[1] = 16'h0003;
    for (int i = 0; i < 2; i++) begin
      xfer(i[0], bad[i], 32'h0000_0020, 32'h1234_5678, 0, 0,
           lat, rd, wl, ol, ov, ca, ra, er, bb);
      exp_do = 32'h0;
      n_cmp++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_resp %h: lat %0d err %0d do %h want 2/1/0", bad[i], lat, er, rd); end
      n_cmp++; if (ca !== 2'b11 || wl !== 0 || ol !== 0) begin n_bad++; $display("FAIL err_strobe %h: ce %b we %0d oe %0d want 11/0/0", bad[i], ca, wl, ol); end
      @(posedge clk); #1;
      n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", m_err); end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; sel = 16'h0001; addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    exp_do = 32'h0;
    n_cmp++;
    if ({a_ce, a_oe, a_ack, a_rdata} !== {2'b11, 1'b1, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_mid: ce %b oe %b ack %b do %h want 11/1/1/0", a_ce, a_oe, a_ack, a_rdata);
    end
    stb = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ack, a_ce, a_oe, a_we, a_be} !== 9'b1_11_1_1_1111) begin
      n_bad++;
      $display("FAIL rst_idle: got %b want 111111111", {a_ack, a_ce, a_oe, a_we, a_be});
    end
  endtask

  task automatic test_back_to_back;
    int lat, wl, ol; logic [31:0] rd, v; bit ov, ov2, er, bb;
    logic [1:0] ca; logic [19:0] ra;
    v = $urandom;
    xfer(1'b0, 16'h0001, 32'h0000_0010, 32'h0, 0, 1,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    exp_do = ref_rd(0, 4);
    n_cmp++; if (rd !== exp_do || lat !== RC_A + 1) begin n_bad++; $display("FAIL b2b_rd: got %h lat %0d want %h lat %0d", rd, lat, exp_do, RC_A + 1); end
    xfer(1'b1, 16'h0002, 32'h0000_001C, v, 1, 0,
         lat, rd, wl, ol, ov2, ca, ra, er, bb);
    ref1[7] = v;
    n_cmp++; if (lat !== WC_A + 2 || wl !== WC_A || ca !== 2'b01) begin n_bad++; $display("FAIL b2b_wr: lat %0d we %0d ce %b want %0d/%0d/01", lat, wl, ca, WC_A + 2, WC_A); end
    n_cmp++; if (ov || ov2) begin n_bad++; $display("FAIL b2b_overlap: got %0d%0d want 00", ov, ov2); end
    xfer(1'b0, 16'h0002, 32'h0000_001C, 32'h0, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    exp_do = ref_rd(1, 7);
    n_cmp++; if (rd !== exp_do) begin n_bad++; $display("FAIL b2b_back: got %h want %h", rd, exp_do); end
  endtask

  task automatic test_random;
    int lat, wl, ol, w, chip, kind; logic [31:0] rd, d, ad;
    bit ov, er, bb, is_err; logic w_e;
    logic [1:0] ca; logic [19:0] ra; logic [15:0] s;
    logic [15:0] bad [4];
    bad[0] = 16'h0004; bad[1] = 16'h0003; bad[2] = 16'h8000; bad[3] = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      is_err = (kind == 0);
      chip = $urandom_range(0, 1);
      s = is_err ? bad[$urandom_range(0, 3)] : 16'(1 << chip);
      w = $urandom_range(0, 15);
      w_e = 1'($urandom);
      d = $urandom;
      ad = {10'($urandom), 20'(w), 2'($urandom)};
      xfer(w_e, s, ad, d, 0, 0, lat, rd, wl, ol, ov, ca, ra, er, bb);
      if (is_err) exp_do = 32'h0;
      else if (!w_e) exp_do = ref_rd(chip, w);
      else if (chip == 0) ref0[w] = d;
      else ref1[w] = d;
      n_cmp++;
      if (lat !== (is_err ? 2 : (w_e ? WC_A + 2 : RC_A + 1))) begin
        n_bad++; $display("FAIL rnd%0d_lat: got %0d sel %h we %0d", i, lat, s, w_e);
      end
      n_cmp++;
      if (rd !== exp_do || er !== is_err) begin
        n_bad++; $display("FAIL rnd%0d_resp: do %h err %0d want %h/%0d", i, rd, er, exp_do, is_err);
      end
      n_cmp++;
      if (ca !== (is_err ? 2'b11 : ~2'(1 << chip)) || ov || bb) begin
        n_bad++; $display("FAIL rnd%0d_bus: ce %b ov %0d be %0d", i, ca, ov, bb);
      end
      n_cmp++;
      if (wl !== ((w_e && !is_err) ? WC_A : 0) || ol !== ((!w_e && !is_err) ? RC_A : 0)) begin
        n_bad++; $display("FAIL rnd%0d_strobe: we %0d oe %0d", i, wl, ol);
      end
      if (!is_err) begin
        n_cmp++;
        if (ra !== 20'(w)) begin n_bad++; $display("FAIL rnd%0d_addr: got %h want %h", i, ra, 20'(w)); end
      end
    end
  endtask

  task automatic test_params;
    int lat, wl, ol; logic [31:0] rd, v; bit ov, er, bb;
    logic [1:0] ca; logic [19:0] ra;
    stb = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk) use_b = 1'b1;
    v = $urandom;
    xfer(1'b1, 16'h0001, 32'h0000_0024, v, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    ref0[9] = v;
    n_cmp++; if (lat !== WC_B + 2 || wl !== WC_B) begin n_bad++; $display("FAIL prm_wr: lat %0d we %0d want %0d/%0d", lat, wl, WC_B + 2, WC_B); end
    xfer(1'b0, 16'h0001, 32'h0000_0024, 32'h0, 0, 0,
         lat, rd, wl, ol, ov, ca, ra, er, bb);
    n_cmp++; if (lat !== RC_B + 1 || ol !== RC_B) begin n_bad++; $display("FAIL prm_rd_lat: lat %0d oe %0d want %0d/%0d", lat, ol, RC_B + 1, RC_B); end
    n_cmp++; if (rd !== ref_rd(0, 9)) begin n_bad++; $display("FAIL prm_rd_data: got %h want %h", rd, ref_rd(0, 9)); end
  endtask

  initial begin
    test_reset();
    test_base_wr();
    test_ext_read();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
